// File: rtl/doorbell_task_fifo_pkg.sv
// rtl/doorbell_task_fifo_pkg.sv - shared doorbell task width and field layout
package doorbell_task_fifo_pkg;

    localparam int DOORBELL_TASK_WIDTH = 128;

    // Optional field view; the FIFO itself treats tasks as opaque bits.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] value;
        logic [15:0] queue_id;
        logic [15:0] flags;
    } doorbell_task_t;

endpackage

// File: rtl/doorbell_task_fifo_mem.sv
// rtl/doorbell_task_fifo_mem.sv - register array, one write port, one async read port
module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             pcie_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge pcie_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/doorbell_task_fifo.sv
// rtl/doorbell_task_fifo.sv - FWFT doorbell task FIFO with occupancy and sticky error status
module doorbell_task_fifo
    import doorbell_task_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = DOORBELL_TASK_WIDTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                     pcie_clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     doorbell_task_q_enq_en,
    input  logic [WIDTH-1:0]         doorbell_task_q_data,
    output logic                     doorbell_task_q_full,
    output logic                     almost_full,
    input  logic                     deq_en,
    output logic [WIDTH-1:0]         deq_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   high_water,
    output logic                     err_overflow,
    output logic                     err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] hw_q;
    logic          ovf_q;
    logic          udf_q;
    logic          full_w;
    logic          empty_w;
    logic          enq_ok;
    logic          deq_ok;

    // Full/empty come only from the registered count: no same-cycle bypass.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);
    assign enq_ok  = doorbell_task_q_enq_en && !full_w;
    assign deq_ok  = deq_en && !empty_w;

    always_comb begin
        count_nxt = count_q;
        if (enq_ok && !deq_ok) begin
            count_nxt = count_q + CW'(1);
        end else if (deq_ok && !enq_ok) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            hw_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clr) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            hw_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (enq_ok) begin
                wp_q <= wp_q + AW'(1);
            end
            if (deq_ok) begin
                rp_q <= rp_q + AW'(1);
            end
            count_q <= count_nxt;
            if (count_nxt > hw_q) begin
                hw_q <= count_nxt;
            end
            if (doorbell_task_q_enq_en && full_w) begin
                ovf_q <= 1'b1;
            end
            if (deq_en && empty_w) begin
                udf_q <= 1'b1;
            end
        end
    end

    // clr also gates the write so a flushed cycle leaves the array untouched.
    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .pcie_clk (pcie_clk),
        .we       (enq_ok && !clr),
        .waddr    (wp_q),
        .wdata    (doorbell_task_q_data),
        .raddr    (rp_q),
        .rdata    (deq_data)
    );

    assign doorbell_task_q_full = full_w;
    assign almost_full          = (count_q >= AF_CNT);
    assign empty                = empty_w;
    assign count                = count_q;
    assign high_water           = hw_q;
    assign err_overflow         = ovf_q;
    assign err_underflow        = udf_q;

endmodule

// File: tb/tb_doorbell_task_fifo.sv
// tb/tb_doorbell_task_fifo.sv - directed self-checking bench for doorbell_task_fifo
module tb_doorbell_task_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 128;
    localparam int CW    = 5;

    logic             pcie_clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             enq_en;
    logic [WIDTH-1:0] enq_data;
    logic             q_full;
    logic             almost_full;
    logic             deq_en;
    logic [WIDTH-1:0] deq_data;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    high_water;
    logic             err_overflow;
    logic             err_underflow;

    int n_cmp = 0;
    int n_err = 0;

    doorbell_task_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AF_THRESH (DEPTH - 2)
    ) dut (
        .pcie_clk               (pcie_clk),
        .rst_n                  (rst_n),
        .clr                    (clr),
        .doorbell_task_q_enq_en (enq_en),
        .doorbell_task_q_data   (enq_data),
        .doorbell_task_q_full   (q_full),
        .almost_full            (almost_full),
        .deq_en                 (deq_en),
        .deq_data               (deq_data),
        .empty                  (empty),
        .count                  (count),
        .high_water             (high_water),
        .err_overflow           (err_overflow),
        .err_underflow          (err_underflow)
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] task_word(input int i);
        return {32'hD00D_0000 + 32'(i), 32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 32'h3333_0000 + 32'(i)};
    endfunction

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_full"}, WIDTH'(q_full), '0);
        chk({pfx, "_af"}, WIDTH'(almost_full), '0);
        chk({pfx, "_empty"}, WIDTH'(empty), WIDTH'(1));
        chk({pfx, "_count"}, WIDTH'(count), '0);
        chk({pfx, "_hw"}, WIDTH'(high_water), '0);
        chk({pfx, "_ovf"}, WIDTH'(err_overflow), '0);
        chk({pfx, "_udf"}, WIDTH'(err_underflow), '0);
    endtask

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] a5_word;

    initial begin
        int sent;
        int recv;
        int cyc;
        logic do_enq;
        logic do_deq;

        rst_n = 1'b0; clr = 1'b0; enq_en = 1'b0; deq_en = 1'b0; enq_data = '0;
        a5_word = {{15{8'hA5}}, 8'h01};
        repeat (2) tick();
        chk_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // single enqueue then dequeue
        enq_en = 1'b1; enq_data = a5_word;
        tick();
        enq_en = 1'b0;
        chk("single_empty", WIDTH'(empty), '0);
        chk("single_data", deq_data, a5_word);
        chk("single_count", WIDTH'(count), WIDTH'(1));
        deq_en = 1'b1;
        tick();
        deq_en = 1'b0;
        chk("single_empty_after", WIDTH'(empty), WIDTH'(1));
        chk("single_count_after", WIDTH'(count), '0);
        chk("single_hw", WIDTH'(high_water), WIDTH'(1));

        // fill to full
        for (int k = 1; k <= DEPTH; k++) begin
            enq_en = 1'b1; enq_data = task_word(k - 1);
            tick();
            chk($sformatf("fill_count_%0d", k), WIDTH'(count), WIDTH'(k));
            chk($sformatf("fill_af_%0d", k), WIDTH'(almost_full), WIDTH'(k >= 14));
            chk($sformatf("fill_full_%0d", k), WIDTH'(q_full), WIDTH'(k == 16));
        end
        enq_data = {4{32'hBAD0_BAD0}};
        tick();
        enq_en = 1'b0;
        chk("ovf_flag", WIDTH'(err_overflow), WIDTH'(1));
        chk("ovf_count", WIDTH'(count), WIDTH'(16));
        chk("ovf_hw", WIDTH'(high_water), WIDTH'(16));
        chk("ovf_head", deq_data, task_word(0));

        // full with enq and deq together
        enq_en = 1'b1; deq_en = 1'b1; enq_data = {4{32'hBAD1_BAD1}};
        tick();
        enq_en = 1'b0;
        chk("fullboth_count", WIDTH'(count), WIDTH'(15));
        chk("fullboth_head", deq_data, task_word(1));
        chk("fullboth_ovf", WIDTH'(err_overflow), WIDTH'(1));
        chk("fullboth_full", WIDTH'(q_full), '0);

        // drain, checking order; the rejected task must never appear
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("drain_data_%0d", k), deq_data, task_word(k));
            tick();
        end
        deq_en = 1'b0;
        chk("drain_empty", WIDTH'(empty), WIDTH'(1));
        chk("drain_udf", WIDTH'(err_underflow), '0);

        // empty with enq and deq together
        enq_en = 1'b1; deq_en = 1'b1; enq_data = {4{32'hC0DE_0042}};
        tick();
        enq_en = 1'b0; deq_en = 1'b0;
        chk("emptyboth_udf", WIDTH'(err_underflow), WIDTH'(1));
        chk("emptyboth_count", WIDTH'(count), WIDTH'(1));
        chk("emptyboth_head", deq_data, {4{32'hC0DE_0042}});
        deq_en = 1'b1;
        tick();
        deq_en = 1'b0;

        // clr with errors set and count 5, alongside an enqueue
        for (int k = 0; k < 5; k++) begin
            enq_en = 1'b1; enq_data = task_word(100 + k);
            tick();
        end
        enq_en = 1'b0;
        chk("preclr_count", WIDTH'(count), WIDTH'(5));
        clr = 1'b1; enq_en = 1'b1; enq_data = task_word(200);
        tick();
        clr = 1'b0; enq_en = 1'b0;
        chk("clr_count", WIDTH'(count), '0);
        chk("clr_hw", WIDTH'(high_water), '0);
        chk("clr_ovf", WIDTH'(err_overflow), '0);
        chk("clr_udf", WIDTH'(err_underflow), '0);
        chk("clr_empty", WIDTH'(empty), WIDTH'(1));

        // stream 40 tasks with gaps against a queue model
        sent = 0; recv = 0; cyc = 0;
        while (recv < 40 && cyc < 400) begin
            do_enq = (sent < 40) && ((cyc % 5) != 3) && (model_q.size() < DEPTH);
            do_deq = (model_q.size() > 0) && ((cyc % 3) != 0) && (cyc >= 4);
            enq_en = do_enq; deq_en = do_deq; enq_data = task_word(1000 + sent);
            if (do_deq) begin
                chk($sformatf("stream_data_%0d", recv), deq_data, model_q[0]);
            end
            tick();
            if (do_deq) begin
                void'(model_q.pop_front());
                recv++;
            end
            if (do_enq) begin
                model_q.push_back(task_word(1000 + sent));
                sent++;
            end
            chk($sformatf("stream_count_c%0d", cyc), WIDTH'(count), WIDTH'(model_q.size()));
            cyc++;
        end
        enq_en = 1'b0; deq_en = 1'b0;
        chk("stream_recv", WIDTH'(recv), WIDTH'(40));
        chk("stream_ovf", WIDTH'(err_overflow), '0);
        chk("stream_udf", WIDTH'(err_underflow), '0);

        // asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            enq_en = 1'b1; enq_data = task_word(300 + k);
            tick();
        end
        deq_en = 1'b1; enq_data = task_word(303);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        enq_en = 1'b0; deq_en = 1'b0;
        tick();
        chk_reset_values("held_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
